// File: rtl/udp_gen_pkg.sv
// Shared types and constants for the IPv4/UDP test-frame generator:
// FSM states, header offsets, fixed header fields and the payload clamp.
package udp_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CSUM1,
    ST_CSUM2,
    ST_SEND,
    ST_FIN,
    ST_GAP
  } state_t;

  // Byte offsets of each header inside the Ethernet frame.
  localparam int ETH_OFF   = 0;
  localparam int IP_OFF    = 14;
  localparam int UDP_OFF   = 34;
  localparam int PAY_OFF   = 42;
  localparam int HDR_BYTES = PAY_OFF + 4;  // headers plus the 4 MAGIC bytes
  localparam int PLEN_MIN  = 18;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [15:0] IP_VER_IHL_TOS = 16'h4500;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
  localparam logic [15:0] IP_ID_INIT     = 16'h0001;

  function automatic logic [10:0] clamp_plen(input logic [10:0] len,
                                             input logic [10:0] max_len);
    if (len < 11'(PLEN_MIN)) return 11'(PLEN_MIN);
    if (len > max_len)       return max_len;
    return len;
  endfunction

endpackage

// File: rtl/udp_frame_gen_if.sv
// PHY TX FIFO write port carried by the frame generator.
// phy_wr_en is a write strobe already qualified by !phy_full: a word phy_din is
// transferred on every rising clock edge where phy_wr_en is high, never otherwise.
interface udp_frame_gen_if;
  logic [8:0] phy_din;
  logic       phy_wr_en;
  logic       phy_full;

  modport master (output phy_din, output phy_wr_en, input phy_full);
  modport slave  (input phy_din, input phy_wr_en, output phy_full);
endinterface

// File: rtl/udp_frame_gen_csum.sv
// Two-cycle IPv4 header checksum: sum_en registers the 20-bit word sum,
// fold_en folds the carries twice and registers the one's complement.
module ipv4_csum
  import udp_gen_pkg::*;
#(
  parameter logic [7:0] IP_TTL = 8'h40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sum_en,
  input  logic        fold_en,
  input  logic [15:0] ip_len,
  input  logic [15:0] ip_id,
  input  logic [31:0] src_ip,
  input  logic [31:0] dst_ip,
  output logic [15:0] csum
);

  logic [19:0] sum_r;
  logic [19:0] sum_c;
  logic [16:0] fold1;
  logic [15:0] fold2;

  // Flags/fragment word is zero, so it does not appear in the sum.
  assign sum_c = 20'(IP_VER_IHL_TOS) + 20'(ip_len) + 20'(ip_id) + 20'({IP_TTL, IP_PROTO_UDP})
               + 20'(src_ip[31:16]) + 20'(src_ip[15:0])
               + 20'(dst_ip[31:16]) + 20'(dst_ip[15:0]);

  assign fold1 = {1'b0, sum_r[15:0]} + 17'(sum_r[19:16]);
  assign fold2 = fold1[15:0] + 16'(fold1[16]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r <= '0;
      csum  <= '0;
    end else begin
      if (sum_en)  sum_r <= sum_c;
      if (fold_en) csum  <= ~fold2;
    end
  end

endmodule

// File: rtl/udp_frame_gen.sv
// IPv4/UDP test-frame generator writing {tx_en, byte} words into the PHY TX FIFO.
// Build option IPID_INC_EN: ip_id steps by one after every frame instead of staying 1.
module udp_frame_gen
  import udp_gen_pkg::*;
#(
  parameter int          PAYLOAD_MAX = 1472,
  parameter int          GAP_CYCLES  = 100000,
  parameter logic [15:0] UDP_PORT    = 16'h0d5e,
  parameter logic [31:0] MAGIC       = 32'ha1110000,
  parameter logic [7:0]  IP_TTL      = 8'h40
) (
  input  logic                   pcie_clk,
  input  logic                   sys_rst_n,
  input  logic                   start,
  input  logic                   cont_mode,
  input  logic [10:0]            payload_len,
  input  logic [47:0]            src_mac,
  input  logic [47:0]            dst_mac,
  input  logic [31:0]            src_ip,
  input  logic [31:0]            dst_ip,
  udp_frame_gen_if.master        phy,
  output logic                   busy,
  output logic [31:0]            frame_cnt,
  output state_t                 state_dbg
);

  state_t      state, state_n;
  logic [10:0] plen_r;
  logic [47:0] src_mac_r, dst_mac_r;
  logic [31:0] src_ip_r, dst_ip_r;
  logic [10:0] byte_idx;
  logic [31:0] gap_cnt;
  logic [15:0] ip_id;
  logic [15:0] csum;
  logic [15:0] ip_len, udp_len;
  logic [10:0] frame_len;
  logic        last_byte;
  logic [HDR_BYTES*8-1:0] hdr;
  logic [5:0]  hdr_pos;
  logic [7:0]  tx_byte;

  assign ip_len    = {5'd0, plen_r} + 16'(PAY_OFF - IP_OFF);
  assign udp_len   = {5'd0, plen_r} + 16'(PAY_OFF - UDP_OFF);
  assign frame_len = plen_r + 11'(PAY_OFF - ETH_OFF);
  assign last_byte = (byte_idx == frame_len - 11'd1);
  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

  assign hdr = {dst_mac_r, src_mac_r, ETHERTYPE_IPV4, IP_VER_IHL_TOS, ip_len, ip_id,
                16'h0000, IP_TTL, IP_PROTO_UDP, csum, src_ip_r, dst_ip_r,
                UDP_PORT, UDP_PORT, udp_len, 16'h0000, MAGIC};

  // Header bytes come from the packed vector, payload byte k is simply k[7:0].
  assign hdr_pos = 6'(HDR_BYTES - 1) - byte_idx[5:0];
  assign tx_byte = (byte_idx < 11'(HDR_BYTES)) ? hdr[{hdr_pos, 3'b000} +: 8]
                                               : byte_idx[7:0] - 8'(PAY_OFF);

  ipv4_csum #(.IP_TTL(IP_TTL)) u_csum (
    .clk     (pcie_clk),
    .rst_n   (sys_rst_n),
    .sum_en  (state == ST_CSUM1),
    .fold_en (state == ST_CSUM2),
    .ip_len  (ip_len),
    .ip_id   (ip_id),
    .src_ip  (src_ip_r),
    .dst_ip  (dst_ip_r),
    .csum    (csum)
  );

  always_ff @(posedge pcie_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= ST_IDLE;
    else            state <= state_n;
  end

  always_comb begin
    state_n       = state;
    phy.phy_wr_en = 1'b0;
    phy.phy_din   = 9'h000;
    case (state)
      ST_IDLE:  if (start || cont_mode) state_n = ST_CSUM1;
      ST_CSUM1: state_n = ST_CSUM2;
      ST_CSUM2: state_n = ST_SEND;
      ST_SEND: begin
        phy.phy_wr_en = !phy.phy_full;
        phy.phy_din   = {1'b1, tx_byte};
        if (!phy.phy_full && last_byte) state_n = ST_FIN;
      end
      ST_FIN: begin
        phy.phy_wr_en = !phy.phy_full;
        if (!phy.phy_full) state_n = ST_GAP;
      end
      ST_GAP:   if (gap_cnt <= 32'd1) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // Configuration is captured only when leaving IDLE, so mid-frame port changes are inert.
  always_ff @(posedge pcie_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      plen_r    <= 11'(PLEN_MIN);
      src_mac_r <= '0;
      dst_mac_r <= '0;
      src_ip_r  <= '0;
      dst_ip_r  <= '0;
      byte_idx  <= '0;
      gap_cnt   <= '0;
      frame_cnt <= '0;
    end else begin
      if (state == ST_IDLE && (start || cont_mode)) begin
        plen_r    <= clamp_plen(payload_len, 11'(PAYLOAD_MAX));
        src_mac_r <= src_mac;
        dst_mac_r <= dst_mac;
        src_ip_r  <= src_ip;
        dst_ip_r  <= dst_ip;
        byte_idx  <= '0;
      end
      if (state == ST_SEND && phy.phy_wr_en) byte_idx <= byte_idx + 11'd1;
      if (state == ST_FIN && phy.phy_wr_en) begin
        frame_cnt <= frame_cnt + 32'd1;
        gap_cnt   <= 32'(GAP_CYCLES);
      end
      if (state == ST_GAP && gap_cnt != 32'd0) gap_cnt <= gap_cnt - 32'd1;
    end
  end

`ifdef IPID_INC_EN
  always_ff @(posedge pcie_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                         ip_id <= IP_ID_INIT;
    else if (state == ST_FIN && phy.phy_wr_en) ip_id <= ip_id + 16'd1;
  end
`else
  assign ip_id = IP_ID_INIT;
`endif

endmodule
